// File: rtl/spi_shift_ctrl.sv
// rtl/spi_shift_ctrl.sv - SPI master serial shift engine driven by clock-generator edge strobes
module spi_shift_ctrl #(
  parameter int MAX_CHAR      = 32,
  parameter int CHAR_LEN_BITS = 5
) (
  input  logic                     wb_clk,
  input  logic                     wb_reset,
  input  logic                     go,
  input  logic [CHAR_LEN_BITS-1:0] len,
  input  logic                     lsb,
  input  logic                     tx_negedge,
  input  logic                     rx_negedge,
  input  logic                     cpol_0,
  input  logic                     cpol_1,
  input  logic                     miso,
  input  logic [MAX_CHAR-1:0]      p_in,
  output logic                     tip,
  output logic                     lstclk,
  output logic                     mosi,
  output logic [MAX_CHAR-1:0]      p_out,
  output logic                     done
);

  localparam int CW = CHAR_LEN_BITS + 1;
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] MAX_L = CW'(MAX_CHAR);

  typedef enum logic {ST_IDLE, ST_XFER} state_t;

  state_t state, state_nxt;

  logic [CW-1:0] len_q, rise_cnt, fall_cnt;
  logic          lsb_q, tx_neg_q, rx_neg_q;

  logic [CW-1:0] len_eff, fall_p1, rise_nxt, fall_nxt, tx_ord, rx_ord;
  logic [CHAR_LEN_BITS-1:0] tx_pos, rx_pos, go_pos;
  logic accept, rise_stb, fall_stb, finish, tx_fire, rx_fire;

  // Map a bit ordinal onto its p_out position for the latched bit order.
  function automatic logic [CHAR_LEN_BITS-1:0] ord2pos(
    input logic [CW-1:0] ord,
    input logic [CW-1:0] l,
    input logic          lsb_first
  );
    logic [CW-1:0] p;
    p = lsb_first ? ord : (l - ord - ONE);
    return p[CHAR_LEN_BITS-1:0];
  endfunction

  assign tip = (state == ST_XFER);

  always_comb begin
    len_eff  = (len == '0) ? MAX_L : {1'b0, len};
    accept   = go && !tip;
    rise_stb = tip && cpol_0;
    fall_stb = tip && cpol_1;
    fall_p1  = fall_cnt + ONE;
    finish   = fall_stb && (fall_p1 == len_q);
    rise_nxt = rise_stb ? (rise_cnt + ONE) : rise_cnt;
    fall_nxt = fall_stb ? fall_p1 : fall_cnt;

    tx_fire  = tx_neg_q ? (fall_stb && (fall_p1 < len_q)) : (rise_stb && (rise_cnt < len_q));
    tx_ord   = tx_neg_q ? fall_p1 : rise_cnt;
    rx_fire  = rx_neg_q ? (fall_stb && (fall_cnt < len_q)) : (rise_stb && (rise_cnt < len_q));
    rx_ord   = rx_neg_q ? fall_cnt : rise_cnt;

    tx_pos   = ord2pos(tx_ord, len_q, lsb_q);
    rx_pos   = ord2pos(rx_ord, len_q, lsb_q);
    go_pos   = ord2pos('0, len_eff, lsb);
  end

  always_comb begin
    state_nxt = state;
    if (accept)
      state_nxt = ST_XFER;
    else if (finish)
      state_nxt = ST_IDLE;
  end

  always_ff @(posedge wb_clk) begin
    if (wb_reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge wb_clk) begin
    if (wb_reset) begin
      len_q    <= '0;
      lsb_q    <= 1'b0;
      tx_neg_q <= 1'b0;
      rx_neg_q <= 1'b0;
      rise_cnt <= '0;
      fall_cnt <= '0;
      lstclk   <= 1'b0;
      mosi     <= 1'b0;
      p_out    <= '0;
      done     <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        len_q    <= len_eff;
        lsb_q    <= lsb;
        tx_neg_q <= tx_negedge;
        rx_neg_q <= rx_negedge;
        rise_cnt <= '0;
        fall_cnt <= '0;
        lstclk   <= 1'b0;
        p_out    <= p_in;
        if (tx_negedge)
          mosi <= p_in[go_pos];
      end else if (tip) begin
        rise_cnt <= rise_nxt;
        fall_cnt <= fall_nxt;
        lstclk   <= !finish && (rise_nxt == len_q);
        // Transmit reads p_out before this edge's receive write lands.
        if (tx_fire)
          mosi <= p_out[tx_pos];
        if (rx_fire)
          p_out[rx_pos] <= miso;
      end
    end
  end

endmodule

// File: tb/tb_spi_shift_ctrl.sv
// tb/tb_spi_shift_ctrl.sv - directed self-checking bench for spi_shift_ctrl
module tb_spi_shift_ctrl;

  logic        wb_clk = 1'b0;
  logic        wb_reset;
  logic        go;
  logic [4:0]  len;
  logic        lsb, tx_negedge, rx_negedge;
  logic        cpol_0, cpol_1;
  logic        miso;
  logic [31:0] p_in;
  logic        tip, lstclk, mosi, done;
  logic [31:0] p_out;

  logic loop_en;
  logic miso_val;

  int n_checks = 0;
  int n_pass   = 0;

  assign miso = loop_en ? mosi : miso_val;

  always #5 wb_clk = ~wb_clk;

  spi_shift_ctrl #(.MAX_CHAR(32), .CHAR_LEN_BITS(5)) dut (
    .wb_clk     (wb_clk),
    .wb_reset   (wb_reset),
    .go         (go),
    .len        (len),
    .lsb        (lsb),
    .tx_negedge (tx_negedge),
    .rx_negedge (rx_negedge),
    .cpol_0     (cpol_0),
    .cpol_1     (cpol_1),
    .miso       (miso),
    .p_in       (p_in),
    .tip        (tip),
    .lstclk     (lstclk),
    .mosi       (mosi),
    .p_out      (p_out),
    .done       (done)
  );

  task automatic tick;
    @(negedge wb_clk);
  endtask

  task automatic rise;
    cpol_0 = 1'b1;
    @(negedge wb_clk);
    cpol_0 = 1'b0;
  endtask

  task automatic fall;
    cpol_1 = 1'b1;
    @(negedge wb_clk);
    cpol_1 = 1'b0;
  endtask

  task automatic start(input logic [4:0] l, input logic lb, input logic tn, input logic rn,
                       input logic [31:0] d, input logic with_stb);
    len = l; lsb = lb; tx_negedge = tn; rx_negedge = rn; p_in = d;
    go = 1'b1;
    cpol_0 = with_stb;
    @(negedge wb_clk);
    go = 1'b0;
    cpol_0 = 1'b0;
  endtask

  task automatic test_reset;
    loop_en = 1'b1;
    start(5'd8, 1'b0, 1'b1, 1'b0, 32'h0000_00A5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      rise; fall;
    end
    wb_reset = 1'b1; go = 1'b1;
    tick; tick;
    n_checks++; if (tip !== 1'b0) $display("FAIL reset_tip got %b want 0", tip); else n_pass++;
    n_checks++; if (lstclk !== 1'b0) $display("FAIL reset_lstclk got %b want 0", lstclk); else n_pass++;
    n_checks++; if (mosi !== 1'b0) $display("FAIL reset_mosi got %b want 0", mosi); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_checks++; if (p_out !== 32'h0) $display("FAIL reset_p_out got %h want 00000000", p_out); else n_pass++;
    wb_reset = 1'b0; go = 1'b0;
    tick;
    n_checks++; if (tip !== 1'b0) $display("FAIL reset_release_tip got %b want 0", tip); else n_pass++;
  endtask

  task automatic test_mode0;
    logic [7:0] exp_bits;
    exp_bits = 8'b1010_0101;
    loop_en = 1'b1;
    start(5'd8, 1'b0, 1'b1, 1'b0, 32'h0000_00A5, 1'b0);
    n_checks++; if (tip !== 1'b1) $display("FAIL m0_tip_start got %b want 1", tip); else n_pass++;
    n_checks++; if (mosi !== exp_bits[7]) $display("FAIL m0_mosi_first got %b want %b", mosi, exp_bits[7]); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      rise;
      n_checks++;
      if (lstclk !== (i == 7)) $display("FAIL m0_lstclk bit %0d got %b want %b", i, lstclk, (i == 7));
      else n_pass++;
      fall;
      if (i < 7) begin
        n_checks++;
        if (mosi !== exp_bits[6-i]) $display("FAIL m0_mosi bit %0d got %b want %b", i + 1, mosi, exp_bits[6-i]);
        else n_pass++;
      end
    end
    n_checks++; if (done !== 1'b1) $display("FAIL m0_done got %b want 1", done); else n_pass++;
    n_checks++; if (tip !== 1'b0) $display("FAIL m0_tip_end got %b want 0", tip); else n_pass++;
    n_checks++; if (lstclk !== 1'b0) $display("FAIL m0_lstclk_end got %b want 0", lstclk); else n_pass++;
    n_checks++; if (p_out !== 32'h0000_00A5) $display("FAIL m0_p_out got %h want 000000a5", p_out); else n_pass++;
    tick;
    n_checks++; if (done !== 1'b0) $display("FAIL m0_done_width got %b want 0", done); else n_pass++;
    n_checks++; if (mosi !== 1'b1) $display("FAIL m0_mosi_hold got %b want 1", mosi); else n_pass++;
  endtask

  task automatic test_full_length;
    logic [7:0] exp_seq;
    exp_seq = 8'b0001_1110;
    loop_en = 1'b0; miso_val = 1'b1;
    start(5'd0, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
    for (int i = 0; i < 32; i++) begin
      rise;
      if (i < 8) begin
        n_checks++;
        if (mosi !== exp_seq[7-i]) $display("FAIL full_mosi bit %0d got %b want %b", i, mosi, exp_seq[7-i]);
        else n_pass++;
      end
      n_checks++;
      if (lstclk !== (i == 31)) $display("FAIL full_lstclk bit %0d got %b want %b", i, lstclk, (i == 31));
      else n_pass++;
      fall;
      if (i == 30) begin
        n_checks++; if (tip !== 1'b1) $display("FAIL full_tip_bit30 got %b want 1", tip); else n_pass++;
      end
    end
    n_checks++; if (done !== 1'b1) $display("FAIL full_done got %b want 1", done); else n_pass++;
    n_checks++; if (p_out !== 32'hFFFF_FFFF) $display("FAIL full_p_out got %h want ffffffff", p_out); else n_pass++;
  endtask

  task automatic test_partial;
    loop_en = 1'b0; miso_val = 1'b0;
    start(5'd4, 1'b1, 1'b0, 1'b0, 32'h0000_00FF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rise; fall;
    end
    n_checks++; if (done !== 1'b1) $display("FAIL part_done got %b want 1", done); else n_pass++;
    n_checks++; if (p_out !== 32'h0000_00F0) $display("FAIL part_p_out got %h want 000000f0", p_out); else n_pass++;
  endtask

  // Entered in the cycle done is high; go is also paired with an idle strobe.
  task automatic test_back_to_back;
    loop_en = 1'b1;
    start(5'd8, 1'b0, 1'b0, 1'b1, 32'h0000_005A, 1'b1);
    n_checks++; if (tip !== 1'b1) $display("FAIL b2b_tip got %b want 1", tip); else n_pass++;
    n_checks++; if (mosi !== 1'b1) $display("FAIL b2b_strobe_ignored mosi got %b want 1", mosi); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      rise;
      n_checks++;
      if (lstclk !== (i == 7)) $display("FAIL b2b_lstclk bit %0d got %b want %b", i, lstclk, (i == 7));
      else n_pass++;
      fall;
    end
    n_checks++; if (done !== 1'b1) $display("FAIL b2b_done got %b want 1", done); else n_pass++;
    n_checks++; if (p_out !== 32'h0000_005A) $display("FAIL b2b_p_out got %h want 0000005a", p_out); else n_pass++;
  endtask

  task automatic test_interference;
    loop_en = 1'b1;
    tick;
    start(5'd8, 1'b0, 1'b1, 1'b0, 32'h0000_003C, 1'b0);
    for (int i = 0; i < 3; i++) begin
      rise; fall;
    end
    p_in = 32'hFFFF_FFFF; go = 1'b1;
    tick;
    go = 1'b0;
    n_checks++; if (tip !== 1'b1) $display("FAIL intf_go_tip got %b want 1", tip); else n_pass++;
    n_checks++; if (p_out !== 32'h0000_003C) $display("FAIL intf_go_p_out got %h want 0000003c", p_out); else n_pass++;
    for (int i = 3; i < 5; i++) begin
      rise; fall;
    end
    wb_reset = 1'b1;
    tick;
    wb_reset = 1'b0;
    n_checks++; if (tip !== 1'b0) $display("FAIL intf_rst_tip got %b want 0", tip); else n_pass++;
    n_checks++; if (p_out !== 32'h0) $display("FAIL intf_rst_p_out got %h want 00000000", p_out); else n_pass++;
    tick;
    n_checks++; if (done !== 1'b0) $display("FAIL intf_rst_done got %b want 0", done); else n_pass++;
    rise; fall; rise; fall;
    n_checks++; if (tip !== 1'b0) $display("FAIL idle_tip got %b want 0", tip); else n_pass++;
    n_checks++; if (mosi !== 1'b0) $display("FAIL idle_mosi got %b want 0", mosi); else n_pass++;
    n_checks++; if (p_out !== 32'h0) $display("FAIL idle_p_out got %h want 00000000", p_out); else n_pass++;
    n_checks++; if (lstclk !== 1'b0) $display("FAIL idle_lstclk got %b want 0", lstclk); else n_pass++;
    start(5'd8, 1'b0, 1'b1, 1'b0, 32'h0000_00C3, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rise; fall;
    end
    n_checks++; if (done !== 1'b1) $display("FAIL intf_final_done got %b want 1", done); else n_pass++;
    n_checks++; if (p_out !== 32'h0000_00C3) $display("FAIL intf_final_p_out got %h want 000000c3", p_out); else n_pass++;
  endtask

  initial begin
    wb_reset = 1'b1; go = 1'b0; len = '0; lsb = 1'b0;
    tx_negedge = 1'b0; rx_negedge = 1'b0; cpol_0 = 1'b0; cpol_1 = 1'b0;
    p_in = '0; loop_en = 1'b0; miso_val = 1'b0;
    tick; tick;
    wb_reset = 1'b0;
    tick;
    test_reset;
    test_mode0;
    test_full_length;
    test_partial;
    test_back_to_back;
    test_interference;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_shift_ctrl.md
# spi_shift_ctrl

Serial shift engine for the SPI master, directly downstream of the SPI clock generator. It consumes the generator's one-cycle edge strobes (`cpol_0` before a rising `sclk`, `cpol_1` before a falling `sclk`) to launch MOSI bits and capture MISO bits. It drives `tip` and `lstclk` back to the generator to start and stop `sclk`. It holds one full-duplex character of up to `MAX_CHAR` bits for the register interface.

## Interface
- `MAX_CHAR`, 32: maximum character length in bits.
- `CHAR_LEN_BITS`, 5: width of `len`; `2**CHAR_LEN_BITS == MAX_CHAR`.

- `wb_clk`  in  1  system clock; all logic on its rising edge.
- `wb_reset`  in  1  reset, synchronous, active-high.
- `go`  in  1  start pulse; honoured only while `tip`=0.
- `len`  in  CHAR_LEN_BITS  character length; 0 means `MAX_CHAR`, otherwise 1..`MAX_CHAR`-1.
- `lsb`  in  1  1 = LSB first, 0 = MSB first.
- `tx_negedge`  in  1  1 = launch MOSI on falling `sclk`, 0 = on rising.
- `rx_negedge`  in  1  1 = sample MISO on falling `sclk`, 0 = on rising.
- `cpol_0`  in  1  rise strobe from the clock generator.
- `cpol_1`  in  1  fall strobe from the clock generator.
- `miso`  in  1  serial input.
- `p_in`  in  MAX_CHAR  transmit data, latched on accepted `go`.
- `tip`  out  1  transfer in progress; enables the clock generator.
- `lstclk`  out  1  last clock; the generator completes the current high phase and then parks `sclk` low.
- `mosi`  out  1  serial output, registered.
- `p_out`  out  MAX_CHAR  data register: transmit data, overwritten bit by bit with received data.
- `done`  out  1  one-cycle pulse when a transfer completes.

## Operation
- Effective length L = (`len`==0) ? `MAX_CHAR` : `len`. L, `lsb`, `tx_negedge` and `rx_negedge` are latched on accepted `go` and held for the whole transfer.
- Bit ordinal i (0..L-1) maps to `p_out[i]` when `lsb`=1 and to `p_out[L-1-i]` when `lsb`=0.
- Internal counters `rise_cnt` and `fall_cnt` are each CHAR_LEN_BITS+1 wide. Each counts strobes accepted during `tip`.
- Strobes are ignored while `tip`=0.

**Accepted `go`** (requires `tip`=0):
- Set `tip`=1, `p_out`=`p_in`, and clear both counters.
- If `tx_negedge`=1, also drive `mosi` with ordinal 0 in the same edge.

**Transmit:**
- `tx_negedge`=0: on each `cpol_0` with `rise_cnt`<L, `mosi` takes ordinal `rise_cnt`.
- `tx_negedge`=1: on each `cpol_1` with `fall_cnt`+1<L, `mosi` takes ordinal `fall_cnt`+1.

**Receive:**
- On each rx strobe (`rx_negedge` ? `cpol_1` : `cpol_0`), while the matching counter is <L, write `miso` into the position of ordinal = matching counter.
- If a transmit read and a receive write of the same bit fall on the same edge, the transmit uses the pre-edge value.

**Counting and completion:**
- `cpol_0` increments `rise_cnt`; `cpol_1` increments `fall_cnt`.
- `lstclk` = `tip` && (`rise_cnt`==L), registered. This blocks the generator's (L+1)-th rising edge.
- On the `cpol_1` that makes `fall_cnt`==L: `tip`←0 and `done`←1 for one cycle; the counters freeze.

**Idle and error behaviour:**
- `go` while `tip`=1 is ignored.
- After completion, `mosi` and `p_out` hold their values until the next accepted `go`.
- Bits of `p_out` at positions ≥L keep their `p_in` value.

## Timing
- Reset values, applied on the edge where `wb_reset`=1: `tip`=0, `lstclk`=0, `mosi`=0, `done`=0, `p_out`=0, counters 0.
- Reset has priority over `go` and over strobes.
- Reset mid-transfer aborts the transfer with no `done` pulse.
- `tip` rises on the edge that samples `go`=1 and falls on the edge that samples the L-th `cpol_1`.
- `done` is high in the cycle after that edge, for exactly one cycle.
- `lstclk` rises on the edge sampling the L-th `cpol_0` and falls together with `tip`.
- `mosi` and `p_out` update on the same edge where the strobe is sampled high; this is the edge where the generator toggles `sclk`.
- Strobe and `go` in the same idle cycle: the strobe is ignored and `go` is accepted.
- `go` in the cycle `done` is high is accepted.

## Test plan
- Reset: assert `wb_reset` for 2 cycles mid-stream → every output 0 on the next edge; `go`=1 held with reset → `tip` stays 0.
- Mode 0: L=8, `lsb`=0, `tx_negedge`=1, `rx_negedge`=0, `p_in`=0xA5, `miso` looped from `mosi`:
  - `mosi` bits 1,0,1,0,0,1,0,1, with the first bit driven at `go`.
  - `lstclk` rises after the 8th `cpol_0`.
  - `done` pulses after the 8th `cpol_1`; `p_out`=0x000000A5.
- Full length: `len`=0, `lsb`=1, `tx_negedge`=0, `rx_negedge`=1, `p_in`=0x12345678, `miso`=1:
  - `mosi` sequence starts 0,0,0,1,1,1,1,0.
  - `done` pulses after 32 falls; `p_out`=0xFFFFFFFF.
- Partial length: `len`=4, `lsb`=1, `p_in`=0x000000FF, `miso`=0 → `p_out`=0x000000F0 (bits 31:4 untouched).
- Interference: `go` pulsed at bit 3 → ignored. Strobes while idle → no output change. Reset at bit 5 → `tip`=0 next edge, no `done`. A following `go` with L=8 completes with a correct loopback result.
